// File: rtl/fft_result_unloader_if.sv
// rtl/fft_result_unloader_if.sv - result stream interface for the FFT result unloader
//
// Carries one result word per beat from the unloader to the downstream consumer.
//   tdata  : result word (two complex samples packed as left/right)
//   tvalid : beat valid, driven by the master
//   tready : downstream ready, driven by the slave
//   tlast  : marks the final beat of the frame
interface fft_result_unloader_if #(
    parameter int wordlen = 32
) ();
    logic [wordlen-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/fft_result_unloader.sv
// rtl/fft_result_unloader.sv - drains the FFT result BRAM onto a result stream
//
// Optional build macro: FFT_UNLOADER_BITREV_EN (bit-reversed read order).
//
// Ports:
//   clk_i        : system clock
//   rstn_i       : synchronous active-low reset
//   start_i      : one-cycle request to begin unloading (ignored while busy)
//   busy_o       : high from accepted start until the final handshake
//   done_o       : one-cycle pulse on the cycle after the final handshake
//   bram_en_o    : BRAM port A read strobe
//   bram_we_o    : BRAM port A write enable, always 0
//   bram_addr_o  : BRAM port A word address, holds when no read is issued
//   bram_din_o   : BRAM port A write data, always 0
//   bram_dout_i  : BRAM port A read data, valid one cycle after bram_en_o
//   m_axis       : result stream master (tdata/tvalid/tready/tlast)
module fft_result_unloader #(
    parameter int points  = 1024,
    parameter int stages  = 10,
    parameter int wordlen = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [stages-2:0]     bram_addr_o,
    output logic [wordlen-1:0]    bram_din_o,
    input  logic [wordlen-1:0]    bram_dout_i,
    fft_result_unloader_if.master m_axis
);

    localparam int addrbits = stages - 1;
    localparam int nwords   = points / 2;

    typedef logic [addrbits:0]   rd_cnt_t;
    typedef logic [addrbits-1:0] addr_t;

    localparam rd_cnt_t rd_last   = rd_cnt_t'(nwords - 1);
    localparam addr_t   beat_last = addr_t'(nwords - 1);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_read  = 2'd1;
    localparam logic [1:0] st_drain = 2'd2;
    localparam logic [1:0] st_done  = 2'd3;

    logic [1:0]         state;
    rd_cnt_t            rd_cnt;
    addr_t              beat_cnt;
    addr_t              addr_q;
    addr_t              rd_addr;
    logic               in_flight;
    logic [wordlen-1:0] buf_head;
    logic [wordlen-1:0] buf_tail;
    logic [1:0]         buf_cnt;
    logic               tvalid;
    logic               pop;
    logic               issue;
    logic [2:0]         occ_next;

`ifdef FFT_UNLOADER_BITREV_EN
    function automatic addr_t bit_reverse(input addr_t a);
        addr_t r;
        r = '0;
        for (int i = 0; i < addrbits; i++) begin
            r[i] = a[addrbits-1-i];
        end
        return r;
    endfunction

    // The in-place FFT leaves results in bit-reversed positions; reading in
    // bit-reversed order restores natural frequency order on the stream.
    assign rd_addr = bit_reverse(rd_cnt[addrbits-1:0]);
`else
    assign rd_addr = rd_cnt[addrbits-1:0];
`endif

    assign tvalid = (buf_cnt != 2'd0);
    assign pop    = tvalid & m_axis.tready;

    // Words that will be held after this cycle: buffered + the word arriving
    // from last cycle's read - the word leaving now. A new read lands one
    // cycle later, possibly with no pop, so it is only safe below 2.
    assign occ_next = {1'b0, buf_cnt} + {2'b00, in_flight} - {2'b00, pop};
    assign issue    = (state == st_read) && (occ_next < 3'd2);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= st_idle;
            rd_cnt    <= '0;
            beat_cnt  <= '0;
            addr_q    <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                rd_cnt <= rd_cnt + rd_cnt_t'(1);
                addr_q <= rd_addr;
            end
            if (pop) begin
                beat_cnt <= beat_cnt + addr_t'(1);
            end
            case (state)
                st_idle: begin
                    if (start_i) begin
                        state    <= st_read;
                        rd_cnt   <= '0;
                        beat_cnt <= '0;
                    end
                end
                st_read: begin
                    // Leave on the cycle that issues the last read.
                    if (issue && (rd_cnt == rd_last)) begin
                        state <= st_drain;
                    end
                end
                st_drain: begin
                    if (pop && (beat_cnt == beat_last)) begin
                        state <= st_done;
                    end
                end
                st_done: begin
                    state <= st_idle;
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

    // Two-entry prefetch FIFO. The head only changes on a pop, which keeps
    // tdata stable while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            buf_head <= '0;
            buf_tail <= '0;
            buf_cnt  <= 2'd0;
        end else begin
            case ({in_flight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_head <= bram_dout_i;
                    end else begin
                        buf_tail <= bram_dout_i;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= bram_dout_i;
                    end else begin
                        buf_head <= bram_dout_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o      = (state == st_read) || (state == st_drain);
    assign done_o      = (state == st_done);
    assign bram_en_o   = issue;
    assign bram_we_o   = 1'b0;
    assign bram_din_o  = '0;
    assign bram_addr_o = issue ? rd_addr : addr_q;

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = buf_head;
    assign m_axis.tlast  = tvalid && (beat_cnt == beat_last);

endmodule
